// File: rtl/hack_kbd_pkg.sv
// Shared constants, FSM state types and the PS/2 set-2 to Hack key-code map
// for the memory-mapped keyboard front end.
package hack_kbd_pkg;

    localparam logic [7:0] KEY_NEWLINE   = 8'd128;
    localparam logic [7:0] KEY_BACKSPACE = 8'd129;
    localparam logic [7:0] KEY_LEFT      = 8'd130;
    localparam logic [7:0] KEY_UP        = 8'd131;
    localparam logic [7:0] KEY_RIGHT     = 8'd132;
    localparam logic [7:0] KEY_DOWN      = 8'd133;
    localparam logic [7:0] KEY_ESC       = 8'd140;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        FRM_IDLE,
        FRM_DATA,
        FRM_PARITY,
        FRM_STOP
    } frame_state_t;

    typedef enum logic [1:0] {
        DEC_NORMAL,
        DEC_EXT,
        DEC_BRK,
        DEC_EXT_BRK
    } dec_state_t;

    // Returns 0 for any key without a Hack code.
    function automatic logic [7:0] ps2_to_hack(input logic ext, input logic [7:0] code);
        logic [7:0] key;
        key = 8'd0;
        if (ext) begin
            case (code)
                8'h6B:   key = KEY_LEFT;
                8'h75:   key = KEY_UP;
                8'h74:   key = KEY_RIGHT;
                8'h72:   key = KEY_DOWN;
                default: key = 8'd0;
            endcase
        end else begin
            case (code)
                8'h1C: key = 8'd65;  8'h32: key = 8'd66;  8'h21: key = 8'd67;
                8'h23: key = 8'd68;  8'h24: key = 8'd69;  8'h2B: key = 8'd70;
                8'h34: key = 8'd71;  8'h33: key = 8'd72;  8'h43: key = 8'd73;
                8'h3B: key = 8'd74;  8'h42: key = 8'd75;  8'h4B: key = 8'd76;
                8'h3A: key = 8'd77;  8'h31: key = 8'd78;  8'h44: key = 8'd79;
                8'h4D: key = 8'd80;  8'h15: key = 8'd81;  8'h2D: key = 8'd82;
                8'h1B: key = 8'd83;  8'h2C: key = 8'd84;  8'h3C: key = 8'd85;
                8'h2A: key = 8'd86;  8'h1D: key = 8'd87;  8'h22: key = 8'd88;
                8'h35: key = 8'd89;  8'h1A: key = 8'd90;
                8'h45: key = 8'd48;  8'h16: key = 8'd49;  8'h1E: key = 8'd50;
                8'h26: key = 8'd51;  8'h25: key = 8'd52;  8'h2E: key = 8'd53;
                8'h36: key = 8'd54;  8'h3D: key = 8'd55;  8'h3E: key = 8'd56;
                8'h46: key = 8'd57;
                8'h29: key = 8'd32;
                8'h5A: key = KEY_NEWLINE;
                8'h66: key = KEY_BACKSPACE;
                8'h76: key = KEY_ESC;
                default: key = 8'd0;
            endcase
        end
        return key;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: line synchronisers, run-length glitch filters, 11-bit frame
// FSM with parity/stop checking and an inter-edge timeout.
module ps2_rx
    import hack_kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 2500
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FW-1:0] RUN_MAX = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES - 1);

    logic          clk_p0, clk_p1, clk_p2, clk_p3;
    logic          dat_p0, dat_p1, dat_p2;
    logic [FW-1:0] clk_run, dat_run;
    logic          fall;

    frame_state_t  state, state_next;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] tcnt;
    logic          shift_en, par_en, valid_next, err_next;

    // Stage p0/p1: synchronisers; p2: filtered levels; p3: edge history.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_p0  <= 1'b1;
            clk_p1  <= 1'b1;
            clk_p2  <= 1'b1;
            clk_p3  <= 1'b1;
            dat_p0  <= 1'b1;
            dat_p1  <= 1'b1;
            dat_p2  <= 1'b1;
            clk_run <= '0;
            dat_run <= '0;
        end else begin
            clk_p0 <= ps2_clk;
            clk_p1 <= clk_p0;
            dat_p0 <= ps2_data;
            dat_p1 <= dat_p0;
            clk_p3 <= clk_p2;
            if (clk_p1 != clk_p2) begin
                if (clk_run == RUN_MAX) begin
                    clk_p2  <= clk_p1;
                    clk_run <= '0;
                end else begin
                    clk_run <= clk_run + 1'b1;
                end
            end else begin
                clk_run <= '0;
            end
            if (dat_p1 != dat_p2) begin
                if (dat_run == RUN_MAX) begin
                    dat_p2  <= dat_p1;
                    dat_run <= '0;
                end else begin
                    dat_run <= dat_run + 1'b1;
                end
            end else begin
                dat_run <= '0;
            end
        end
    end

    assign fall = clk_p3 & ~clk_p2;

    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        par_en     = 1'b0;
        valid_next = 1'b0;
        err_next   = 1'b0;
        case (state)
            FRM_IDLE: begin
                if (fall && !dat_p2) state_next = FRM_DATA;
            end
            FRM_DATA: begin
                if (fall) begin
                    shift_en = 1'b1;
                    if (bitcnt == 3'd7) state_next = FRM_PARITY;
                end
            end
            FRM_PARITY: begin
                if (fall) begin
                    par_en     = 1'b1;
                    state_next = FRM_STOP;
                end
            end
            FRM_STOP: begin
                if (fall) begin
                    state_next = FRM_IDLE;
                    if (dat_p2 && (^{shreg, par_bit})) valid_next = 1'b1;
                    else                               err_next   = 1'b1;
                end
            end
            default: state_next = FRM_IDLE;
        endcase
        // A keyboard that stops clocking mid-frame abandons the frame.
        if (state != FRM_IDLE && !fall && tcnt == TO_MAX) begin
            state_next = FRM_IDLE;
            err_next   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FRM_IDLE;
            bitcnt     <= 3'd0;
            shreg      <= 8'd0;
            par_bit    <= 1'b0;
            tcnt       <= '0;
            data_byte  <= 8'd0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_next;
            byte_valid <= valid_next;
            frame_err  <= err_next;
            if (state == FRM_IDLE || fall) tcnt <= '0;
            else                           tcnt <= tcnt + 1'b1;
            if (state == FRM_IDLE) bitcnt <= 3'd0;
            else if (shift_en)     bitcnt <= bitcnt + 1'b1;
            if (shift_en)   shreg     <= {dat_p2, shreg[7:1]};
            if (par_en)     par_bit   <= dat_p2;
            if (valid_next) data_byte <= shreg;
        end
    end

endmodule

// File: rtl/keyboard_ctrl.sv
// Hack keyboard register front end: decodes PS/2 make/break/E0 sequences and
// holds the Hack code of the most recently pressed, still-held key.
module keyboard_ctrl
    import hack_kbd_pkg::*;
#(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 2500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] out,
    output logic        frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid, rx_err;
    dec_state_t dec, dec_next;
    logic       make_en, brk_en, key_ext;
    logic [7:0] key_code;
    logic [7:0] key_p1;
    logic       err_p1;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .data_byte  (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (rx_err)
    );

    always_comb begin
        dec_next = dec;
        make_en  = 1'b0;
        brk_en   = 1'b0;
        key_ext  = (dec == DEC_EXT) || (dec == DEC_EXT_BRK);
        if (rx_valid) begin
            case (dec)
                DEC_NORMAL: begin
                    if (rx_byte == PS2_EXT)      dec_next = DEC_EXT;
                    else if (rx_byte == PS2_BRK) dec_next = DEC_BRK;
                    else                         make_en  = 1'b1;
                end
                DEC_EXT: begin
                    if (rx_byte == PS2_BRK) begin
                        dec_next = DEC_EXT_BRK;
                    end else if (rx_byte != PS2_EXT) begin
                        make_en  = 1'b1;
                        dec_next = DEC_NORMAL;
                    end
                end
                DEC_BRK, DEC_EXT_BRK: begin
                    brk_en   = 1'b1;
                    dec_next = DEC_NORMAL;
                end
                default: dec_next = DEC_NORMAL;
            endcase
        end
    end

    assign key_code = ps2_to_hack(key_ext, rx_byte);

    // Stage p1: decoded key and delayed error, aligned to the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            dec    <= DEC_NORMAL;
            key_p1 <= 8'd0;
            err_p1 <= 1'b0;
        end else begin
            dec    <= dec_next;
            err_p1 <= rx_err;
            if (make_en && key_code != 8'd0)    key_p1 <= key_code;
            else if (brk_en && key_code == key_p1) key_p1 <= 8'd0;
        end
    end

    assign out       = {8'h00, key_p1};
    assign frame_err = err_p1;

endmodule

// File: doc/keyboard_ctrl.md
Name: keyboard_ctrl

Overview:
- Front-end controller for the Hack memory-mapped keyboard register at address 24576 (0x6000).
- Receives PS/2 scan-code set 2 frames from a physical keyboard and tracks make, break and extended (E0) prefixes.
- Translates each key to its Hack key code and drives the 16-bit value the CPU reads.
- `out` holds the code of the most recently pressed key that is still held, and 0 when no key is held.

Parameters:
- FILTER_LEN, 4: consecutive identical synchronised samples required before `ps2_clk` or `ps2_data` changes filtered level.
- TIMEOUT_CYCLES, 2500: maximum `clk` cycles between falling `ps2_clk` edges inside a frame before the frame is aborted.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- ps2_clk  input  1  PS/2 clock from the keyboard; asynchronous.
- ps2_data  input  1  PS/2 data from the keyboard; asynchronous.
- out  output  16  Hack key code; bits [15:8] are always 0.
- frame_err  output  1  one-cycle pulse on a parity, stop-bit or timeout error.

Behaviour:
- Interface: one clock, `clk`. Reset is `reset`, synchronous and active-high; on the `clk` edge where `reset`=1, all registers clear.
- Reset values: `out`=0, `frame_err`=0, both FSMs in IDLE/NORMAL, timeout counter 0, filtered lines = 1.
- Reset mid-frame discards all partial frame and prefix state.
- Input conditioning: each line passes a 2-flop synchroniser, then the FILTER_LEN majority-free run filter.
- A falling edge is filtered `ps2_clk` going 1->0. It is a one-cycle internal strobe `fall`.
- Frame FSM, all sampling of filtered `ps2_data` on `fall`:
  - IDLE: a start bit of 0 -> DATA with bit count 0. A start bit of 1 is ignored and the FSM stays in IDLE.
  - DATA: shift in 8 bits, LSB first, then -> PARITY.
  - PARITY: store the bit, -> STOP.
  - STOP: frame is valid if the stop bit = 1 and the 9 bits (data + parity) have odd parity. Valid -> one-cycle `byte_valid` with `byte`. Invalid -> `frame_err` pulse. Either way -> IDLE.
  - Timeout: in any state except IDLE, the counter counts `clk` cycles since the last `fall`. Reaching TIMEOUT_CYCLES -> IDLE plus a `frame_err` pulse. The counter resets on every `fall`.
- Decoder FSM, advancing on `byte_valid`; states NORMAL, EXT, BRK, EXT_BRK:
  - NORMAL: E0 -> EXT; F0 -> BRK; any other byte = make code (ext=0), stay NORMAL.
  - EXT: F0 -> EXT_BRK; E0 stays EXT; any other byte = make code (ext=1), -> NORMAL.
  - BRK: any byte = break code (ext=0), -> NORMAL.
  - EXT_BRK: any byte = break code (ext=1), -> NORMAL.
- Make: if the mapped code is nonzero, `out` <= code. Unmapped keys (map 0) leave `out` unchanged. Typematic repeats rewrite the same value.
- Break: if mapped code == current `out`, `out` <= 0. Otherwise `out` is unchanged; an older held key is not restored.
- Latency: `out` and `frame_err` update exactly 2 `clk` cycles after the cycle in which the stop-bit `fall` is seen.
- Mapping, `{ext,byte}` -> 8-bit code:
  - Letters -> uppercase ASCII 65-90 (A=0x1C->65, Z=0x1A->90).
  - Digits 0-9 -> 48-57 (1=0x16->49).
  - Space 0x29->32.
  - Enter 0x5A->128; Backspace 0x66->129; Esc 0x76->140.
  - Extended: left E0 6B->130, up E0 75->131, right E0 74->132, down E0 72->133.
  - Shift state is not tracked.

Decomposition:
- Package `hack_kbd_pkg` holds:
  - Hack key-code constants (KEY_NEWLINE=128 ... KEY_ESC=140).
  - PS/2 prefix constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
  - Frame-FSM and decoder-FSM state enums.
  - The combinational mapping function `ps2_to_hack(ext, byte)`.
- Sub-module `ps2_rx`: synchroniser, filter, frame FSM and timeout. Outputs `byte`, `byte_valid` and `frame_err`.
- `keyboard_ctrl` instantiates `ps2_rx` and contains the decoder FSM and the `out` register.

Test Plan:
- Reset asserted for 2 cycles during a partial frame (4 bits sent) -> `out`=0, no `frame_err`. A following full frame 0x1C decodes normally -> `out`=65.
- Frames 1C, F0 1C -> `out`=65 two cycles after the first stop bit. `out`=0 two cycles after the F0-1C stop bit.
- Extended E0 75, then E0 F0 75 -> `out`=131, then 0. A plain 75 make (no E0) must not produce 131.
- Overlap: 1C (A), 32 (B), F0 1C -> `out` goes 65 then 66, and stays 66 after A's break. F0 32 -> 0.
- Bad parity on byte 0x29 -> `frame_err` pulses 1 cycle, `out` unchanged. Stop bit 0 -> same result.
- Send 5 bits, then hold `ps2_clk` high > TIMEOUT_CYCLES -> `frame_err` pulse. A following valid 0x5A frame gives `out`=128.
- Glitch: a `ps2_clk` low pulse shorter than FILTER_LEN cycles produces no bit.
